// File: rtl/cv32e40p_apu_core_pkg.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_core_pkg
// Shared APU width constants for the cv32e40p core, the shared-FPU arbiter
// types, and the helper that sizes the arbiter's core-ID fields.
// Contents:
//   APU_NARGS_CPU     number of 32-bit operands per APU request
//   APU_WOP_CPU       APU opcode width
//   APU_NDSFLAGS_CPU  downstream (core -> APU) flag width
//   APU_NUSFLAGS_CPU  upstream (APU -> core) flag width
//   apu_arb_lock_e    arbiter request-lock state
//   apu_arb_id_w()    width of a core index for a given number of cores
// -----------------------------------------------------------------------------
package cv32e40p_apu_core_pkg;

  localparam int APU_NARGS_CPU    = 3;
  localparam int APU_WOP_CPU      = 6;
  localparam int APU_NDSFLAGS_CPU = 15;
  localparam int APU_NUSFLAGS_CPU = 5;

  // The arbiter is either free to pick a new core each cycle, or locked onto
  // a core whose request has been presented but not yet granted.
  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } apu_arb_lock_e;

  // Core-index width. It never drops below one bit, so the index always has
  // a real vector to live in.
  function automatic int apu_arb_id_w(input int num_req);
    return (num_req > 2) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cv32e40p_apu_arbiter_if.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_arbiter_if
// Bundles the per-core APU master ports and the single FPU-wrapper port that
// the shared-FPU arbiter sits between. Signal suffixes are from the
// arbiter's point of view.
// Modports:
//   slave  : the arbiter (takes core requests and FPU responses, drives
//            grants, result valids, and the FPU request)
//   master : the environment (cores plus the FPU wrapper)
// Signals:
//   req_apu_req_i / gnt_o / operands_i / op_i / flags_i   per-core request
//   req_apu_rvalid_o / rdata_o / rflags_o                  core response
//   fpu_apu_req_o / gnt_i / operands_o / op_o / flags_o    FPU request
//   fpu_apu_rvalid_i / rdata_i / rflags_i                  FPU response
// -----------------------------------------------------------------------------
interface cv32e40p_apu_arbiter_if #(
  parameter int NUM_REQ = 2
);
  import cv32e40p_apu_core_pkg::*;

  logic [NUM_REQ-1:0]                         req_apu_req_i;
  logic [NUM_REQ-1:0]                         req_apu_gnt_o;
  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0] req_apu_operands_i;
  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]        req_apu_op_i;
  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]   req_apu_flags_i;
  logic [NUM_REQ-1:0]                         req_apu_rvalid_o;
  logic [31:0]                                req_apu_rdata_o;
  logic [APU_NUSFLAGS_CPU-1:0]                req_apu_rflags_o;

  logic                                       fpu_apu_req_o;
  logic                                       fpu_apu_gnt_i;
  logic [APU_NARGS_CPU-1:0][31:0]             fpu_apu_operands_o;
  logic [APU_WOP_CPU-1:0]                     fpu_apu_op_o;
  logic [APU_NDSFLAGS_CPU-1:0]                fpu_apu_flags_o;
  logic                                       fpu_apu_rvalid_i;
  logic [31:0]                                fpu_apu_rdata_i;
  logic [APU_NUSFLAGS_CPU-1:0]                fpu_apu_rflags_i;

  modport slave (
    input  req_apu_req_i, req_apu_operands_i, req_apu_op_i, req_apu_flags_i,
    output req_apu_gnt_o, req_apu_rvalid_o, req_apu_rdata_o, req_apu_rflags_o,
    output fpu_apu_req_o, fpu_apu_operands_o, fpu_apu_op_o, fpu_apu_flags_o,
    input  fpu_apu_gnt_i, fpu_apu_rvalid_i, fpu_apu_rdata_i, fpu_apu_rflags_i
  );

  modport master (
    output req_apu_req_i, req_apu_operands_i, req_apu_op_i, req_apu_flags_i,
    input  req_apu_gnt_o, req_apu_rvalid_o, req_apu_rdata_o, req_apu_rflags_o,
    input  fpu_apu_req_o, fpu_apu_operands_o, fpu_apu_op_o, fpu_apu_flags_o,
    output fpu_apu_gnt_i, fpu_apu_rvalid_i, fpu_apu_rdata_i, fpu_apu_rflags_i
  );

endinterface

// File: rtl/cv32e40p_apu_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_arb_id_fifo
// In-order queue of core IDs for operations that have been issued to the FPU
// but have not yet returned. The head is the owner of the next FPU result.
// Ports:
//   clk_i, rst_i  clock and asynchronous active-high reset
//   push_i, id_i  enqueue id_i (ignored when full)
//   pop_i         dequeue the head (ignored when empty)
//   head_o        oldest stored ID
//   full_o        DEPTH entries stored
//   empty_o       no entries stored
//   count_o       current occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module cv32e40p_apu_arb_id_fifo #(
  parameter int DEPTH = 4,
  parameter int ID_W  = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [ID_W-1:0]          id_i,
  output logic [ID_W-1:0]          head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];
  assign count_o = count_q;

  // ID storage needs no reset: an entry is only read after it has been
  // written, because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wptr_q] <= id_i;
    end
  end

  // Pointers wrap at DEPTH; the count tracks occupancy so a simultaneous
  // push and pop leaves it unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) begin
        wptr_q <= (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rptr_q <= (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cv32e40p_apu_arbiter.sv
// -----------------------------------------------------------------------------
// cv32e40p_apu_arbiter
// Shares one APU/FPU wrapper between NUM_REQ cores. It makes round-robin
// grants and locks onto a presented-but-ungranted request so that the
// operands seen by the FPU stay stable. An ID FIFO routes each in-order FPU
// result back to the core that issued it. Both the request path and the
// response path are combinational.
// Ports:
//   clk_i, rst_i   clock and asynchronous active-high reset
//   bus            cv32e40p_apu_arbiter_if.slave (cores <-> FPU traffic)
//   outstanding_o  number of issued operations still waiting for a result
//   err_o          sticky: an FPU result arrived with no owner
// -----------------------------------------------------------------------------
module cv32e40p_apu_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  cv32e40p_apu_arbiter_if.slave            bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                             err_o
);
  import cv32e40p_apu_core_pkg::*;

  localparam int ID_W = apu_arb_id_w(NUM_REQ);

  logic [ID_W-1:0]    rr_ptr_q, sel_q, sel, cand, rr_next;
  apu_arb_lock_e      lock_q;
  logic               err_q;
  logic               found, any_req, fpu_req, handshake, bypass, push, pop;
  logic               fifo_full, fifo_empty;
  logic [ID_W-1:0]    head_id;
  logic [NUM_REQ-1:0] gnt_vec, rvalid_vec;

  // Pick the requester: the locked core if a request is pending, otherwise
  // the first requesting core at or after the round-robin pointer.
  always_comb begin
    sel   = rr_ptr_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q == ARB_LOCKED) begin
      sel = sel_q;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (!found && bus.req_apu_req_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign any_req   = |bus.req_apu_req_i;
  assign fpu_req   = any_req && !fifo_full;
  assign handshake = fpu_req && bus.fpu_apu_gnt_i;

  // A result that returns in the same cycle as its grant, with nothing
  // older in flight, belongs to the core being granted. It never enters
  // the FIFO.
  assign bypass = fifo_empty && handshake && bus.fpu_apu_rvalid_i;
  assign push   = handshake && !bypass;
  assign pop    = bus.fpu_apu_rvalid_i && !fifo_empty;

  assign rr_next = (int'(sel) == NUM_REQ - 1) ? '0 : sel + ID_W'(1);

  assign bus.fpu_apu_req_o      = fpu_req;
  assign bus.fpu_apu_operands_o = bus.req_apu_operands_i[sel];
  assign bus.fpu_apu_op_o       = bus.req_apu_op_i[sel];
  assign bus.fpu_apu_flags_o    = bus.req_apu_flags_i[sel];
  assign bus.req_apu_rdata_o    = bus.fpu_apu_rdata_i;
  assign bus.req_apu_rflags_o   = bus.fpu_apu_rflags_i;
  assign bus.req_apu_gnt_o      = gnt_vec;
  assign bus.req_apu_rvalid_o   = rvalid_vec;

  // One-hot grant to the selected core; one-hot result valid to the owner
  // of the result. An orphan result leaves every valid low.
  always_comb begin
    gnt_vec    = '0;
    rvalid_vec = '0;
    if (handshake) begin
      gnt_vec[sel] = 1'b1;
    end
    if (bypass) begin
      rvalid_vec[sel] = 1'b1;
    end else if (pop) begin
      rvalid_vec[head_id] = 1'b1;
    end
  end

  // Lock, round-robin pointer and sticky error. A request that is presented
  // but not granted locks the choice. A full FIFO suppresses the request,
  // so the lock is held and the same core goes first once space frees.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      sel_q    <= '0;
      lock_q   <= ARB_FREE;
      err_q    <= 1'b0;
    end else begin
      if (handshake) begin
        rr_ptr_q <= rr_next;
        lock_q   <= ARB_FREE;
      end else if (fpu_req) begin
        lock_q <= ARB_LOCKED;
        sel_q  <= sel;
      end
      if (bus.fpu_apu_rvalid_i && fifo_empty && !handshake) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;

  cv32e40p_apu_arb_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .ID_W  (ID_W)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .id_i    (sel),
    .head_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

endmodule
